mem_port_unit: RTL and testbench
================================

MEM_PORT_UNIT -- requirements
Module: mem_port_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, meaning BUSY cycles without bus_ack before abort (range 2..255).
REQ-002 SHALL have clk  input  1  sole clock, rising-edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have mem_read  input  1  load requested by the pipeline.
REQ-005 SHALL have mem_write  input  1  store requested by the pipeline.
REQ-006 SHALL have inst_size  input  2  access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 SHALL have load_unsigned  input  1  zero-extend load (lbu/lhu) when 1.
REQ-008 SHALL have addr  input  32  byte address (ALU result).
REQ-009 SHALL have wdata  input  32  store data; low bits hold the value.
REQ-010 SHALL have stall  output  1  pipeline hold.
REQ-011 SHALL have rdata  output  32  extended load result, valid when done=1.
REQ-012 SHALL have done  output  1  one-cycle completion pulse.
REQ-013 SHALL have misaligned  output  1  alignment or size fault on the current request.
REQ-014 SHALL have bus_err  output  1  one-cycle timeout-abort pulse, coincident with done.
REQ-015 SHALL have bus_req, bus_we  output  1 each  bus request; write when bus_we=1.
REQ-016 SHALL have bus_addr  output  32  word address, {addr[31:2],2'b00}.
REQ-017 SHALL have bus_be  output  4  byte-lane enables.
REQ-018 SHALL have bus_wdata  output  32  lane-replicated store data.
REQ-019 SHALL have bus_ack  input  1  responder completion; bus_rdata  input  32  read word.

Function
REQ-020 SHALL use a three-state FSM: IDLE, BUSY, DONE.
REQ-021 In IDLE with (mem_read|mem_write) and an aligned legal size: SHALL drive stall=1 combinationally, latch all request inputs, and enter BUSY.
REQ-022 If mem_read and mem_write are both 1, SHALL perform a write.
REQ-023 Fault condition: size 11; half with addr[0]=1; word with addr[1:0]!=00.
REQ-024 On a fault in IDLE: SHALL drive misaligned=1 combinationally and stall=0; SHALL issue no bus transaction; FSM SHALL remain in IDLE.
REQ-025 In BUSY: SHALL hold bus_req=1; bus_we, bus_addr, bus_be and bus_wdata SHALL stay stable; stall=1.
REQ-026 In BUSY with bus_ack=1: SHALL register the formatted read data and enter DONE.
REQ-027 In DONE: SHALL drive done=1, stall=0, bus_req=0, and ignore all request inputs; next state SHALL be IDLE.
REQ-028 Minimum latency: request seen in cycle N, bus_req in N+1, ack in N+1, done in N+2.
REQ-029 Byte enables: byte SHALL be 4'b0001<<addr[1:0]; half SHALL be 0011 (addr[1]=0) or 1100 (addr[1]=1); word SHALL be 1111.
REQ-030 bus_wdata: byte SHALL be {4{wdata[7:0]}}; half SHALL be {2{wdata[15:0]}}; word SHALL be wdata.
REQ-031 Load extraction SHALL select lane(s) by latched addr[1:0]; SHALL sign-extend unless load_unsigned=1, then zero-extend.
REQ-032 For a write, rdata SHALL be 0 at done.
REQ-033 A BUSY cycle counter SHALL clear on BUSY entry.
REQ-034 If the counter reaches TIMEOUT without ack: SHALL drop bus_req, enter DONE, and pulse bus_err with done; rdata SHALL be 0.
REQ-035 An ack arriving in the same cycle as the timeout SHALL win: normal completion, no bus_err.
REQ-036 bus_ack in IDLE or DONE SHALL be ignored.
REQ-037 Outside BUSY, bus_be SHALL be 0.

Reset
REQ-038 When reset asserts, SHALL immediately force state IDLE; stall, done, misaligned, bus_err, bus_req and bus_we = 0; rdata, bus_addr, bus_be, bus_wdata and the counter = 0.
REQ-039 Reset asserted mid-BUSY SHALL abort the transaction with no done pulse; a late bus_ack after reset release SHALL be ignored.

Verification
REQ-040 lw addr=0x100, ack on first BUSY cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x100, be=1111, done two cycles after request, rdata=0xDEADBEEF.
REQ-041 lb addr=0x203, bus_rdata=0x80112233 -> be=1000, rdata=0xFFFFFF80; same access as lbu -> rdata=0x00000080.
REQ-042 sh addr=0x12, wdata=0x0000ABCD -> bus_we=1, be=1100, bus_wdata=0xABCDABCD, rdata=0 at done.
REQ-043 lw addr=0x102 -> misaligned=1, stall=0, bus_req never asserts; lh addr=0x101 and size 11 -> same.
REQ-044 sw with no ack, TIMEOUT=16 -> bus_req high 16 cycles, then done=1 and bus_err=1 together; ack on cycle 16 -> no bus_err.
REQ-045 Reset pulsed during BUSY, then ack -> bus_req=0 and stall=0 immediately, no done pulse, FSM in IDLE.

Source files
------------

// File: rtl/mem_port_unit.sv
// mem_port_unit: single-outstanding load/store port between the pipeline and
// a simple req/ack memory bus. It formats byte enables and store data,
// extracts and extends load data, and aborts a bus access after TIMEOUT
// BUSY cycles without an acknowledge.
module mem_port_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  inst_size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        done,
  output logic        misaligned,
  output logic        bus_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Last BUSY cycle index before the abort fires (counter starts at 0).
  localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_size;
  logic [1:0]  r_lo;
  logic        r_uns;
  logic        w_req;
  logic        w_fault;
  logic        w_start;

  // Size 11 is illegal; halves need even addresses, words need 4-byte alignment.
  function automatic logic f_fault(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_fault = 1'b0;
      2'b01:   f_fault = lo[0];
      2'b10:   f_fault = (lo != 2'b00);
      default: f_fault = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] f_be(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      2'b00:   f_be = 4'b0001 << lo;
      2'b01:   f_be = lo[1] ? 4'b1100 : 4'b0011;
      2'b10:   f_be = 4'b1111;
      default: f_be = 4'b0000;
    endcase
  endfunction

  // Replicate the store value across all lanes so the enables pick the right one.
  function automatic logic [31:0] f_wdata(input logic [1:0] size, input logic [31:0] wd);
    case (size)
      2'b00:   f_wdata = {4{wd[7:0]}};
      2'b01:   f_wdata = {2{wd[15:0]}};
      default: f_wdata = wd;
    endcase
  endfunction

  function automatic logic [31:0] f_load(input logic [1:0] size, input logic [1:0] lo,
                                         input logic uns, input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {lo, 3'b000};
    case (size)
      2'b00:   f_load = uns ? {24'h000000, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      2'b01:   f_load = uns ? {16'h0000, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: f_load = word;
    endcase
  endfunction

  assign w_req   = mem_read | mem_write;
  assign w_fault = f_fault(inst_size, addr[1:0]);
  assign w_start = (r_state == ST_IDLE) && w_req && !w_fault;

  // Pipeline hold and fault flag react within the request cycle.
  always_comb begin
    stall      = 1'b0;
    misaligned = 1'b0;
    if (reset) begin
      stall      = 1'b0;
      misaligned = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          stall      = w_start;
          misaligned = w_req && w_fault;
        end
        ST_BUSY: stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  // Transaction FSM: latch request, run bus handshake with timeout, pulse done.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_size    <= 2'b00;
      r_lo      <= 2'b00;
      r_uns     <= 1'b0;
      rdata     <= 32'd0;
      done      <= 1'b0;
      bus_err   <= 1'b0;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= 32'd0;
      bus_be    <= 4'b0000;
      bus_wdata <= 32'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          done    <= 1'b0;
          bus_err <= 1'b0;
          if (w_start) begin
            r_state   <= ST_BUSY;
            r_cnt     <= 8'd0;
            r_size    <= inst_size;
            r_lo      <= addr[1:0];
            r_uns     <= load_unsigned;
            bus_req   <= 1'b1;
            bus_we    <= mem_write;   // a simultaneous read+write is a write
            bus_addr  <= {addr[31:2], 2'b00};
            bus_be    <= f_be(inst_size, addr[1:0]);
            bus_wdata <= f_wdata(inst_size, wdata);
          end
        end
        ST_BUSY: begin
          if (bus_ack) begin
            // ack beats a coincident timeout
            r_state <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'b0000;
            done    <= 1'b1;
            rdata   <= bus_we ? 32'd0 : f_load(r_size, r_lo, r_uns, bus_rdata);
          end else if (r_cnt == LP_TMO_LAST) begin
            r_state <= ST_DONE;
            bus_req <= 1'b0;
            bus_we  <= 1'b0;
            bus_be  <= 4'b0000;
            done    <= 1'b1;
            bus_err <= 1'b1;
            rdata   <= 32'd0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          bus_err <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          done    <= 1'b0;
          bus_err <= 1'b0;
          bus_req <= 1'b0;
          bus_be  <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_unit.sv
// Directed testbench for mem_port_unit with hand-computed expected values.
module tb_mem_port_unit;

  logic        clk;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  inst_size;
  logic        load_unsigned;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] rdata;
  logic        done;
  logic        misaligned;
  logic        bus_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  int checks_r = 0;
  int errors_r = 0;

  mem_port_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .inst_size(inst_size), .load_unsigned(load_unsigned), .addr(addr),
    .wdata(wdata), .stall(stall), .rdata(rdata), .done(done),
    .misaligned(misaligned), .bus_err(bus_err), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_r++;
    if (obs !== exp) begin
      errors_r++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_req();
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    inst_size     = 2'b00;
    load_unsigned = 1'b0;
    addr          = 32'd0;
    wdata         = 32'd0;
  endtask

  // Full legal access; ack_cyc = BUSY cycle carrying ack (0 = never).
  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] rdat, input int ack_cyc,
                        input logic [3:0] e_be, input logic [31:0] e_wd,
                        input logic e_we, input logic [31:0] e_rd,
                        input logic e_err, input int e_reqs);
    int reqs;
    bit seen;
    reqs = 0;
    seen = 1'b0;
    mem_read = rd; mem_write = wr; inst_size = sz; load_unsigned = uns;
    addr = a; wdata = wd;
    @(negedge clk);
    chk({nm, ".stall_req"}, {31'd0, stall}, 32'd1);
    chk({nm, ".mis_req"}, {31'd0, misaligned}, 32'd0);
    chk({nm, ".req_early"}, {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    clr_req();
    for (int i = 0; i < 40; i++) begin
      if (i + 1 == ack_cyc) begin
        bus_ack = 1'b1;
        bus_rdata = rdat;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (bus_req) reqs++;
      if (i == 0) begin
        chk({nm, ".addr"}, bus_addr, {a[31:2], 2'b00});
        chk({nm, ".be"}, {28'd0, bus_be}, {28'd0, e_be});
        chk({nm, ".we"}, {31'd0, bus_we}, {31'd0, e_we});
        chk({nm, ".stall_busy"}, {31'd0, stall}, 32'd1);
        if (e_we) chk({nm, ".wdata"}, bus_wdata, e_wd);
      end
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    chk({nm, ".done"}, {31'd0, seen}, 32'd1);
    chk({nm, ".req_cycles"}, reqs, e_reqs);
    chk({nm, ".rdata"}, rdata, e_rd);
    chk({nm, ".bus_err"}, {31'd0, bus_err}, {31'd0, e_err});
    chk({nm, ".stall_done"}, {31'd0, stall}, 32'd0);
    chk({nm, ".be_done"}, {28'd0, bus_be}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk({nm, ".done_clr"}, {31'd0, done}, 32'd0);
    @(posedge clk); #1;
  endtask

  // Faulting request: must never start a bus transaction.
  task automatic fault(input string nm, input logic [1:0] sz, input logic [31:0] a);
    mem_read = 1'b1; inst_size = sz; addr = a;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk({nm, ".mis"}, {31'd0, misaligned}, 32'd1);
      chk({nm, ".stall"}, {31'd0, stall}, 32'd0);
      chk({nm, ".req"}, {31'd0, bus_req}, 32'd0);
      @(posedge clk); #1;
    end
    clr_req();
    @(negedge clk);
    chk({nm, ".req_after"}, {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    bus_ack = 1'b0;
    bus_rdata = 32'd0;
    clr_req();
    #12;
    chk("rst.stall", {31'd0, stall}, 32'd0);
    chk("rst.done", {31'd0, done}, 32'd0);
    chk("rst.req", {31'd0, bus_req}, 32'd0);
    chk("rst.be", {28'd0, bus_be}, 32'd0);
    chk("rst.rdata", rdata, 32'd0);
    chk("rst.addr", bus_addr, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    access("lw",  1'b1, 1'b0, 2'b10, 1'b0, 32'h100, 32'd0, 32'hDEADBEEF, 1,
           4'b1111, 32'd0, 1'b0, 32'hDEADBEEF, 1'b0, 1);
    access("lb",  1'b1, 1'b0, 2'b00, 1'b0, 32'h203, 32'd0, 32'h80112233, 1,
           4'b1000, 32'd0, 1'b0, 32'hFFFFFF80, 1'b0, 1);
    access("lbu", 1'b1, 1'b0, 2'b00, 1'b1, 32'h203, 32'd0, 32'h80112233, 1,
           4'b1000, 32'd0, 1'b0, 32'h00000080, 1'b0, 1);
    access("lh_hi", 1'b1, 1'b0, 2'b01, 1'b0, 32'h202, 32'd0, 32'h80112233, 3,
           4'b1100, 32'd0, 1'b0, 32'hFFFF8011, 1'b0, 3);
    access("lh_lo", 1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'd0, 32'h1234F00D, 1,
           4'b0011, 32'd0, 1'b0, 32'hFFFFF00D, 1'b0, 1);
    access("lhu", 1'b1, 1'b0, 2'b01, 1'b1, 32'h200, 32'd0, 32'h1234F00D, 1,
           4'b0011, 32'd0, 1'b0, 32'h0000F00D, 1'b0, 1);
    access("sh",  1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000ABCD, 32'hFFFFFFFF, 1,
           4'b1100, 32'hABCDABCD, 1'b1, 32'd0, 1'b0, 1);
    access("sb_rw", 1'b1, 1'b1, 2'b00, 1'b0, 32'h101, 32'h0000005A, 32'hFFFFFFFF, 2,
           4'b0010, 32'h5A5A5A5A, 1'b1, 32'd0, 1'b0, 2);
    access("sw_tmo", 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'd0, 0,
           4'b1111, 32'h11223344, 1'b1, 32'd0, 1'b1, 16);
    access("sw_ack16", 1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'd0, 16,
           4'b1111, 32'h11223344, 1'b1, 32'd0, 1'b0, 16);

    fault("lw_mis", 2'b10, 32'h102);
    fault("lh_mis", 2'b01, 32'h101);
    fault("sz11",   2'b11, 32'h100);

    // Reset in the middle of BUSY, then a late ack.
    mem_read = 1'b1; inst_size = 2'b10; addr = 32'h300;
    @(posedge clk); #1;
    clr_req();
    @(negedge clk);
    chk("rstb.req_busy", {31'd0, bus_req}, 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("rstb.req", {31'd0, bus_req}, 32'd0);
    chk("rstb.stall", {31'd0, stall}, 32'd0);
    chk("rstb.be", {28'd0, bus_be}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ack = 1'b1;
    bus_rdata = 32'h12345678;
    @(negedge clk);
    chk("rstb.done0", {31'd0, done}, 32'd0);
    chk("rstb.req0", {31'd0, bus_req}, 32'd0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    @(negedge clk);
    chk("rstb.done1", {31'd0, done}, 32'd0);
    chk("rstb.rdata", rdata, 32'd0);
    @(posedge clk); #1;

    access("lw_post", 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'd0, 32'hCAFEF00D, 1,
           4'b1111, 32'd0, 1'b0, 32'hCAFEF00D, 1'b0, 1);

    $display("CHECKS %0d ERRORS %0d", checks_r, errors_r);
    $finish;
  end

endmodule
